// File: rtl/mac_out_writeback.sv
// mac_out_writeback: commits finished MAC-array output rows into the 16 x 64-bit
// output memory, either overwriting the stored word or accumulating into it
// (read-add-write) for tiled products. Pulses DONE after the last row of a tile.
//
// Optional build macro: WB_SAT_EN
//   defined   -> accumulate path uses signed saturating per-lane adds
//   undefined -> accumulate path wraps modulo 2^DW per lane
//
// state  | meaning
// IDLE   | waiting for START, no tile in progress
// ARMED  | ROW_READY high, waiting for a row
// RD     | read request for the stored word (accumulate only)
// WAIT   | read data returns, lane-wise add into capture register
// WR     | write result, advance row counter
module mac_out_writeback #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int AW    = 4
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                START,
  input  logic                ACC,
  input  logic                TILE_R,
  input  logic                TILE_C,
  input  logic [2:0]          NROWS,
  input  logic [LANES-1:0]    LANE_MASK,
  input  logic                ROW_VALID,
  output logic                ROW_READY,
  input  logic [DW*LANES-1:0] ROW_DATA,
  output logic                EN_O,
  output logic                RW_O,
  output logic [AW-1:0]       ADDR_O,
  output logic [DW*LANES-1:0] WDATA_O,
  input  logic [DW*LANES-1:0] RDATA_O,
  output logic                BUSY,
  output logic                DONE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;

  logic [2:0]          state;
  logic                acc_q;
  logic                tile_r_q;
  logic                tile_c_q;
  logic [1:0]          last_row_q;
  logic [LANES-1:0]    mask_q;
  logic [1:0]          row_cnt;
  logic [DW*LANES-1:0] cap;
  logic                done_q;
  logic [DW*LANES-1:0] row_masked;
  logic [DW*LANES-1:0] sum_row;
  logic [DW:0]         lane_sum;

  // Mask bits line up with the row word: mask bit j gates bits [j*DW +: DW],
  // so the MSB of the mask covers lane 0 in the top slice.
  always_comb begin
    row_masked = '0;
    for (int j = 0; j < LANES; j++) begin
      row_masked[j*DW +: DW] = mask_q[j] ? ROW_DATA[j*DW +: DW] : '0;
    end
  end

  // Lane-wise add of the captured row and the returned stored word, no cross-lane carry.
  always_comb begin
    sum_row  = '0;
    lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
`ifdef WB_SAT_EN
      lane_sum = {cap[j*DW+DW-1], cap[j*DW +: DW]} + {RDATA_O[j*DW+DW-1], RDATA_O[j*DW +: DW]};
      if (lane_sum[DW] != lane_sum[DW-1]) begin
        sum_row[j*DW +: DW] = lane_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
        sum_row[j*DW +: DW] = lane_sum[DW-1:0];
      end
`else
      lane_sum = {1'b0, cap[j*DW +: DW]} + {1'b0, RDATA_O[j*DW +: DW]};
      sum_row[j*DW +: DW] = lane_sum[DW-1:0];
`endif
    end
  end

  // Sequencer: tile config latch, row capture, read-add-write and row counting.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state      <= S_IDLE;
      acc_q      <= 1'b0;
      tile_r_q   <= 1'b0;
      tile_c_q   <= 1'b0;
      last_row_q <= 2'd0;
      mask_q     <= '0;
      row_cnt    <= 2'd0;
      cap        <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            acc_q      <= ACC;
            tile_r_q   <= TILE_R;
            tile_c_q   <= TILE_C;
            // 0 (and anything above 4) means a full 4-row tile
            last_row_q <= (NROWS > 3'd4) ? 2'd3 : (NROWS[1:0] - 2'd1);
            mask_q     <= LANE_MASK;
            row_cnt    <= 2'd0;
            state      <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (ROW_VALID) begin
            cap   <= row_masked;
            state <= acc_q ? S_RD : S_WR;
          end
        end
        S_RD: state <= S_WAIT;
        S_WAIT: begin
          cap   <= sum_row;
          state <= S_WR;
        end
        S_WR: begin
          row_cnt <= row_cnt + 2'd1;
          if (row_cnt == last_row_q) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            state <= S_ARMED;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from state so a reset drops them on the next edge.
  always_comb begin
    ROW_READY = (state == S_ARMED);
    EN_O      = (state == S_RD) || (state == S_WR);
    RW_O      = (state == S_WR);
    ADDR_O    = '0;
    if ((state == S_RD) || (state == S_WAIT) || (state == S_WR)) begin
      ADDR_O = {tile_r_q, row_cnt, tile_c_q};
    end
    WDATA_O   = (state == S_WR) ? cap : '0;
    BUSY      = (state != S_IDLE);
    DONE      = done_q;
  end

endmodule

// File: tb/tb_mac_out_writeback.sv
// Testbench for mac_out_writeback: environment memory, reference model with
// expectation queue, and an independent monitor comparing every memory access.
module tb_mac_out_writeback;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        START = 1'b0;
  logic        ACC = 1'b0;
  logic        TILE_R = 1'b0;
  logic        TILE_C = 1'b0;
  logic [2:0]  NROWS = 3'd0;
  logic [3:0]  LANE_MASK = 4'h0;
  logic        ROW_VALID = 1'b0;
  logic        ROW_READY;
  logic [63:0] ROW_DATA = 64'h0;
  logic        EN_O;
  logic        RW_O;
  logic [3:0]  ADDR_O;
  logic [63:0] WDATA_O;
  logic [63:0] RDATA_O = 64'h0;
  logic        BUSY;
  logic        DONE;

  mac_out_writeback dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .ACC(ACC), .TILE_R(TILE_R), .TILE_C(TILE_C),
    .NROWS(NROWS), .LANE_MASK(LANE_MASK), .ROW_VALID(ROW_VALID), .ROW_READY(ROW_READY),
    .ROW_DATA(ROW_DATA), .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
    .RDATA_O(RDATA_O), .BUSY(BUSY), .DONE(DONE)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    bit          rw;
    logic [3:0]  addr;
    logic [63:0] data;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem     [16];
  logic [63:0] ref_mem [16];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          exp_dones = 0;

  bit          m_acc, m_tr, m_tc;
  logic [3:0]  m_mask;
  int          m_nrows;
  int          m_row;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_add(logic [15:0] x, logic [15:0] y);
    int s;
`ifdef WB_SAT_EN
    s = int'($signed(x)) + int'($signed(y));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`else
    s = (int'(x) + int'(y)) % 65536;
`endif
    return 16'(s);
  endfunction

  // Reference: lane i of the row is bits [63-16i -: 16]; the mask is read
  // MSB-first so that mask 1100 keeps lanes 0 and 1.
  function automatic void push_row(logic [63:0] d, bit abort);
    logic [3:0]  a;
    logic [63:0] res;
    logic [15:0] lane;
    a   = {m_tr, 2'(m_row), m_tc};
    res = 64'h0;
    for (int i = 0; i < 4; i++) begin
      lane = m_mask[3-i] ? d[63-16*i -: 16] : 16'h0;
      if (m_acc) lane = lane_add(lane, ref_mem[a][63-16*i -: 16]);
      res[63-16*i -: 16] = lane;
    end
    if (m_acc) exp_q.push_back('{1'b0, a, 64'h0, 1'b0});
    if (!abort) begin
      ref_mem[a] = res;
      exp_q.push_back('{1'b1, a, res, (m_row == m_nrows - 1)});
      if (m_row == m_nrows - 1) exp_dones++;
      m_row++;
    end
  endfunction

  // Output memory: access seen during a cycle takes effect at its closing edge.
  initial begin
    logic        e, w;
    logic [3:0]  a;
    logic [63:0] wd;
    forever begin
      @(negedge CLK);
      e = EN_O; w = RW_O; a = ADDR_O; wd = WDATA_O;
      @(posedge CLK);
      if (e === 1'b1) begin
        if (w) mem[a] = wd;
        else   RDATA_O = mem[a];
      end
    end
  end

  // Monitor: every memory access must match the next expectation; DONE must
  // pulse exactly in the cycle after the last write of a tile.
  initial begin
    exp_t e;
    bit   done_due;
    done_due = 1'b0;
    forever begin
      @(negedge CLK);
      check("done", 64'(DONE), 64'(done_due));
      done_due = 1'b0;
      if (DONE === 1'b1) n_done++;
      if (EN_O === 1'b1) begin
        check("access_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rw", 64'(RW_O), 64'(e.rw));
          check("addr", 64'(ADDR_O), 64'(e.addr));
          if (e.rw) begin
            check("wdata", WDATA_O, e.data);
            done_due = e.last;
          end
        end
      end
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_row_ready"}, 64'(ROW_READY), 64'd0);
    check({tag, "_en"},        64'(EN_O), 64'd0);
    check({tag, "_rw"},        64'(RW_O), 64'd0);
    check({tag, "_addr"},      64'(ADDR_O), 64'd0);
    check({tag, "_wdata"},     WDATA_O, 64'd0);
    check({tag, "_busy"},      64'(BUSY), 64'd0);
    check({tag, "_done"},      64'(DONE), 64'd0);
  endtask

  task automatic start_tile(bit acc, bit tr, bit tc, logic [2:0] nr, logic [3:0] mk,
                            bit early, logic [63:0] d0);
    m_acc = acc; m_tr = tr; m_tc = tc; m_mask = mk; m_row = 0;
    m_nrows = (nr == 3'd0 || nr > 3'd4) ? 4 : int'(nr);
    START = 1'b1; ACC = acc; TILE_R = tr; TILE_C = tc; NROWS = nr; LANE_MASK = mk;
    if (early) begin
      ROW_VALID = 1'b1;
      ROW_DATA  = d0;
    end
    cyc();
    START = 1'b0;
    check("busy_after_start", 64'(BUSY), 64'd1);
  endtask

  task automatic send_row(logic [63:0] d, bit abort);
    bit ok;
    ok = 1'b0;
    ROW_VALID = 1'b1;
    ROW_DATA  = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (ROW_READY === 1'b1) begin
        push_row(d, abort);
        ok = 1'b1;
      end
      cyc();
    end
    ROW_VALID = 1'b0;
    check("row_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && BUSY === 1'b1; k++) cyc();
    check("tile_end_busy", 64'(BUSY), 64'd0);
    cyc();
  endtask

  task automatic run_tile(bit acc, bit tr, bit tc, logic [2:0] nr, logic [3:0] mk);
    bit          early;
    logic [63:0] d0;
    early = 1'($urandom_range(0, 1));
    d0    = rnd64();
    start_tile(acc, tr, tc, nr, mk, early, d0);
    for (int r = 0; r < m_nrows; r++) begin
      if (r > 0 || !early) begin
        ROW_VALID = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
      end
      send_row((r == 0) ? d0 : rnd64(), 1'b0);
    end
    wait_idle();
  endtask

  initial begin
    int n_acc;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = rnd64();
      ref_mem[i] = mem[i];
    end

    // reset
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outs("reset");
    RSTN = 1'b0;
    cyc();

    // overwrite, full tile at addresses 0,2,4,6
    run_tile(1'b0, 1'b0, 1'b0, 3'd4, 4'hF);

    // accumulate into word 9
    mem[9] = 64'h0001_0002_0003_0004; ref_mem[9] = mem[9];
    start_tile(1'b1, 1'b1, 1'b1, 3'd1, 4'hF, 1'b0, 64'h0);
    send_row(64'h0010_0020_0030_0040, 1'b0);
    wait_idle();
    check("acc_mem9", mem[9], 64'h0011_0022_0033_0044);

    // lane overflow: wrap or saturate
    mem[0] = 64'h7FFF_7FFF_7FFF_7FFF; ref_mem[0] = mem[0];
    start_tile(1'b1, 1'b0, 1'b0, 3'd1, 4'hF, 1'b0, 64'h0);
    send_row(64'h0001_0001_0001_0001, 1'b0);
    wait_idle();
`ifdef WB_SAT_EN
    check("ovf_mem0", mem[0], 64'h7FFF_7FFF_7FFF_7FFF);
`else
    check("ovf_mem0", mem[0], 64'h8000_8000_8000_8000);
`endif

    // lane mask in overwrite mode
    start_tile(1'b0, 1'b0, 1'b0, 3'd1, 4'b1100, 1'b0, 64'h0);
    send_row(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    wait_idle();
    check("mask_mem0", mem[0], 64'hAAAA_BBBB_0000_0000);

    // ROW_VALID held high, NROWS=2, START while busy ignored
    n_acc = 0;
    start_tile(1'b0, 1'b0, 1'b1, 3'd2, 4'hF, 1'b1, rnd64());
    for (int k = 0; k < 14; k++) begin
      if (k == 1) begin
        START = 1'b1; ACC = 1'b1; TILE_R = 1'b1; NROWS = 3'd4;
      end else begin
        START = 1'b0;
      end
      if (ROW_READY === 1'b1) begin
        push_row(ROW_DATA, 1'b0);
        n_acc++;
      end
      cyc();
      ROW_DATA = rnd64();
    end
    ROW_VALID = 1'b0;
    START = 1'b0;
    check("held_valid_rows", 64'(n_acc), 64'd2);
    check("held_valid_ready_after", 64'(ROW_READY), 64'd0);
    check("held_valid_busy_after", 64'(BUSY), 64'd0);

    // randomized tiles, including NROWS=0 and masked accumulate
    for (int t = 0; t < 25; t++) begin
      run_tile(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 4)), 4'($urandom_range(0, 15)));
    end

    // reset during WAIT: read happens, write must not
    start_tile(1'b1, 1'b0, 1'b1, 3'd2, 4'hF, 1'b0, 64'h0);
    send_row(rnd64(), 1'b1);
    cyc();
    check("in_wait_en", 64'(EN_O), 64'd0);
    check("in_wait_busy", 64'(BUSY), 64'd1);
    RSTN = 1'b1;
    cyc();
    check_reset_outs("abort");
    RSTN = 1'b0;
    repeat (3) cyc();
    check("abort_no_write", mem[4'b0001], ref_mem[4'b0001]);

    repeat (3) cyc();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(n_done), 64'(exp_dones));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
